// File: rtl/uart_receptor.sv
// UART receiver: 16x oversampled start/data/stop framing, LSB first.
// Define UART_RX_FRAMING_ERR_EN to reject frames whose stop bit samples low.
module uart_receptor #(
   parameter int ancho_dato = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  senial_generadorTick,
   input  logic                  RX,
   output logic [ancho_dato-1:0] salida_receptor,
   output logic                  senial_dato_listo,
   output logic                  error_trama
);

   localparam int BitW = (ancho_dato > 1) ? $clog2(ancho_dato) : 1;
   localparam logic [BitW-1:0] LastBit = BitW'(ancho_dato - 1);
   localparam logic [BitW-1:0] BitOne  = BitW'(1);

   localparam logic [1:0] ST_WAIT  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [3:0]            tick_q, tick_d;
   logic [BitW-1:0]       bit_q, bit_d;
   logic [ancho_dato-1:0] shift_q, shift_d;
   logic [ancho_dato-1:0] word_q, word_d;
   logic                  listo_q, listo_d;
   logic                  err_q, err_d;

   // Start is checked at tick 7 (mid start bit); every later sample is 16 ticks on, so mid-bit.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      word_d  = word_q;
      listo_d = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         ST_WAIT: begin
            tick_d = 4'd0;
            bit_d  = '0;
            if (!RX) state_d = ST_START;
         end
         ST_START: begin
            if (senial_generadorTick) begin
               if (tick_q == 4'd7) begin
                  tick_d  = 4'd0;
                  bit_d   = '0;
                  state_d = RX ? ST_WAIT : ST_DATA;
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         ST_DATA: begin
            if (senial_generadorTick) begin
               if (tick_q == 4'd15) begin
                  tick_d  = 4'd0;
                  shift_d = {RX, shift_q[ancho_dato-1:1]};
                  if (bit_q == LastBit) state_d = ST_STOP;
                  else                  bit_d   = bit_q + BitOne;
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         ST_STOP: begin
            if (senial_generadorTick) begin
               if (tick_q == 4'd15) begin
                  tick_d  = 4'd0;
                  state_d = ST_WAIT;
`ifdef UART_RX_FRAMING_ERR_EN
                  if (RX) begin
                     word_d  = shift_q;
                     listo_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
`else
                  word_d  = shift_q;
                  listo_d = 1'b1;
`endif
               end else begin
                  tick_d = tick_q + 4'd1;
               end
            end
         end
         default: state_d = ST_WAIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_WAIT;
         tick_q  <= 4'd0;
         bit_q   <= '0;
         shift_q <= '0;
         word_q  <= '0;
         listo_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         listo_q <= listo_d;
         err_q   <= err_d;
      end
   end

   assign salida_receptor   = word_q;
   assign senial_dato_listo = listo_q;
   assign error_trama       = err_q;

endmodule
